// File: rtl/instr_decode_queue.sv
// Decode stage for OP-IMM/LUI/AUIPC (and OP when DECODER_OP_REG_EN is defined),
// buffering decoded records in a DEPTH-entry FIFO in front of execute.
module instr_decode_queue #(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_instr,
   input  logic [31:0]   in_pc,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [2:0]    out_kind,
   output logic [3:0]    out_func,
   output logic [4:0]    out_rd,
   output logic [4:0]    out_rs1,
   output logic [4:0]    out_rs2,
   output logic [31:0]   out_imm,
   output logic [31:0]   out_pc,
   output logic          out_illegal,
   output logic [CW-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_OP_REG = 7'b0110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [2:0] KIND_UNKNOWN = 3'd0;
   localparam logic [2:0] KIND_OP_IMM  = 3'd1;
   localparam logic [2:0] KIND_LUI     = 3'd2;
   localparam logic [2:0] KIND_AUIPC   = 3'd3;
   localparam logic [2:0] KIND_OP_REG  = 3'd4;

   localparam logic [3:0] FN_ADD  = 4'd0;
   localparam logic [3:0] FN_SUB  = 4'd1;
   localparam logic [3:0] FN_SLT  = 4'd2;
   localparam logic [3:0] FN_SLTU = 4'd3;
   localparam logic [3:0] FN_AND  = 4'd4;
   localparam logic [3:0] FN_OR   = 4'd5;
   localparam logic [3:0] FN_XOR  = 4'd6;
   localparam logic [3:0] FN_SLL  = 4'd7;
   localparam logic [3:0] FN_SRL  = 4'd8;
   localparam logic [3:0] FN_SRA  = 4'd9;

   typedef struct packed {
      logic [2:0]  kind;
      logic [3:0]  func;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        illegal;
   } rec_t;

   rec_t            mem_q [DEPTH];
   logic [AW-1:0]   head_q, head_d;
   logic [AW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;

   logic [2:0]      dec_kind_s;
   logic [3:0]      dec_func_s;
   logic [4:0]      dec_rd_s, dec_rs1_s, dec_rs2_s;
   logic [31:0]     dec_imm_s;
   logic            dec_illegal_s;
   rec_t            dec_rec_s;
   rec_t            head_rec_s;

   logic            in_ready_s, out_valid_s, push_s, pop_s;

   wire logic [6:0] opcode_s = in_instr[6:0];
   wire logic [2:0] funct3_s = in_instr[14:12];
   wire logic [6:0] funct7_s = in_instr[31:25];

   // Combinational decode of the offered instruction word.
   always_comb begin
      dec_kind_s    = KIND_UNKNOWN;
      dec_func_s    = FN_ADD;
      dec_rd_s      = 5'd0;
      dec_rs1_s     = 5'd0;
      dec_rs2_s     = 5'd0;
      dec_imm_s     = 32'd0;
      dec_illegal_s = 1'b0;
      if (in_instr[1:0] != 2'b11) begin
         dec_illegal_s = 1'b1;
      end else begin
         case (opcode_s)
            OPC_OP_IMM: begin
               dec_kind_s = KIND_OP_IMM;
               dec_rd_s   = in_instr[11:7];
               dec_rs1_s  = in_instr[19:15];
               dec_imm_s  = {{20{in_instr[31]}}, in_instr[31:20]};
               case (funct3_s)
                  3'b000: dec_func_s = FN_ADD;
                  3'b010: dec_func_s = FN_SLT;
                  3'b011: dec_func_s = FN_SLTU;
                  3'b100: dec_func_s = FN_XOR;
                  3'b110: dec_func_s = FN_OR;
                  3'b111: dec_func_s = FN_AND;
                  3'b001: begin
                     dec_func_s = FN_SLL;
                     dec_imm_s  = {27'd0, in_instr[24:20]};
                     if (funct7_s != F7_BASE) begin
                        dec_illegal_s = 1'b1;
                     end else begin
                        dec_illegal_s = 1'b0;
                     end
                  end
                  3'b101: begin
                     dec_imm_s = {27'd0, in_instr[24:20]};
                     if (funct7_s == F7_BASE) begin
                        dec_func_s = FN_SRL;
                     end else if (funct7_s == F7_ALT) begin
                        dec_func_s = FN_SRA;
                     end else begin
                        dec_illegal_s = 1'b1;
                     end
                  end
                  default: dec_illegal_s = 1'b1;
               endcase
            end
            OPC_LUI, OPC_AUIPC: begin
               dec_kind_s = (opcode_s == OPC_LUI) ? KIND_LUI : KIND_AUIPC;
               dec_rd_s   = in_instr[11:7];
               dec_imm_s  = {in_instr[31:12], 12'd0};
            end
`ifdef DECODER_OP_REG_EN
            OPC_OP_REG: begin
               dec_kind_s = KIND_OP_REG;
               dec_rd_s   = in_instr[11:7];
               dec_rs1_s  = in_instr[19:15];
               dec_rs2_s  = in_instr[24:20];
               if (funct7_s == F7_BASE) begin
                  case (funct3_s)
                     3'b000:  dec_func_s = FN_ADD;
                     3'b001:  dec_func_s = FN_SLL;
                     3'b010:  dec_func_s = FN_SLT;
                     3'b011:  dec_func_s = FN_SLTU;
                     3'b100:  dec_func_s = FN_XOR;
                     3'b101:  dec_func_s = FN_SRL;
                     3'b110:  dec_func_s = FN_OR;
                     3'b111:  dec_func_s = FN_AND;
                     default: dec_illegal_s = 1'b1;
                  endcase
               end else if (funct7_s == F7_ALT && funct3_s == 3'b000) begin
                  dec_func_s = FN_SUB;
               end else if (funct7_s == F7_ALT && funct3_s == 3'b101) begin
                  dec_func_s = FN_SRA;
               end else begin
                  dec_illegal_s = 1'b1;
               end
            end
`endif
            default: dec_illegal_s = 1'b1;
         endcase
      end
   end

   // Illegal encodings keep only their PC so the downstream trap can report it.
   always_comb begin
      if (dec_illegal_s) begin
         dec_rec_s         = '0;
         dec_rec_s.pc      = in_pc;
         dec_rec_s.illegal = 1'b1;
      end else begin
         dec_rec_s.kind    = dec_kind_s;
         dec_rec_s.func    = dec_func_s;
         dec_rec_s.rd      = dec_rd_s;
         dec_rec_s.rs1     = dec_rs1_s;
         dec_rec_s.rs2     = dec_rs2_s;
         dec_rec_s.imm     = dec_imm_s;
         dec_rec_s.pc      = in_pc;
         dec_rec_s.illegal = 1'b0;
      end
   end

   assign in_ready_s  = (count_q < CNT_FULL) && !flush;
   assign out_valid_s = (count_q != '0);
   assign push_s      = in_valid && in_ready_s;
   assign pop_s       = out_valid_s && out_ready && !flush;

   // Pointer and occupancy next state; flush overrides any transfer.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push_s) begin
            tail_d = tail_q + PTR_ONE;
         end else begin
            tail_d = tail_q;
         end
         if (pop_s) begin
            head_d = head_q + PTR_ONE;
         end else begin
            head_d = head_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // Queue pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage, written at the tail on an accepted transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_s) begin
         mem_q[tail_q] <= dec_rec_s;
      end else begin
         mem_q[tail_q] <= mem_q[tail_q];
      end
   end

   assign head_rec_s  = out_valid_s ? mem_q[head_q] : '0;

   assign in_ready    = in_ready_s;
   assign out_valid   = out_valid_s;
   assign out_kind    = head_rec_s.kind;
   assign out_func    = head_rec_s.func;
   assign out_rd      = head_rec_s.rd;
   assign out_rs1     = head_rec_s.rs1;
   assign out_rs2     = head_rec_s.rs2;
   assign out_imm     = head_rec_s.imm;
   assign out_pc      = head_rec_s.pc;
   assign out_illegal = head_rec_s.illegal;
   assign count       = count_q;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Self-checking bench for instr_decode_queue: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_instr_decode_queue;

   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int ALU_FN [8] = '{0, 7, 2, 3, 6, 8, 5, 4};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_instr = 32'd0;
   logic [31:0]   in_pc = 32'd0;
   logic          flush = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [2:0]    out_kind;
   logic [3:0]    out_func;
   logic [4:0]    out_rd, out_rs1, out_rs2;
   logic [31:0]   out_imm, out_pc;
   logic          out_illegal;
   logic [CW-1:0] count;

   int            checks = 0;
   int            failures = 0;
   logic [86:0]   exp_q [$];
   logic [31:0]   obs_pc [$];
   bit            last_acc = 1'b0;

   instr_decode_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
      .out_func(out_func), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal), .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [86:0] mk(int kind, int func, int rd, int rs1, int rs2,
                                      logic [31:0] imm, logic [31:0] pc, bit ill);
      return {kind[2:0], func[3:0], rd[4:0], rs1[4:0], rs2[4:0], imm, pc, ill};
   endfunction

   function automatic logic [86:0] obs_rec();
      return {out_kind, out_func, out_rd, out_rs1, out_rs2, out_imm, out_pc, out_illegal};
   endfunction

   function automatic logic [86:0] exp_head();
      if (exp_q.size() != 0) return exp_q[0];
      return 87'd0;
   endfunction

   // Reference decoder built from the ISA field rules and a funct3 lookup table.
   function automatic logic [86:0] ref_decode(input logic [31:0] w, input logic [31:0] pc);
      int kind, func, rd, rs1, rs2, f3, f7;
      logic [31:0] imm;
      bit legal;
      kind = 0; func = 0; rd = 0; rs1 = 0; rs2 = 0; imm = 32'd0; legal = 1'b0;
      f3 = int'(w[14:12]);
      f7 = int'(w[31:25]);
      if (w[1:0] == 2'b11) begin
         case (w[6:0])
            7'h13: begin
               kind = 1; rd = int'(w[11:7]); rs1 = int'(w[19:15]); func = ALU_FN[f3];
               if (f3 == 1 || f3 == 5) begin
                  imm = {27'd0, w[24:20]};
                  legal = (f7 == 0) || (f3 == 5 && f7 == 32);
                  if (f3 == 5 && f7 == 32) func = 9;
               end else begin
                  imm = {{20{w[31]}}, w[31:20]};
                  legal = 1'b1;
               end
            end
            7'h37, 7'h17: begin
               kind = (w[6:0] == 7'h37) ? 2 : 3;
               rd = int'(w[11:7]); imm = {w[31:12], 12'd0}; legal = 1'b1;
            end
            7'h33: begin
`ifdef DECODER_OP_REG_EN
               kind = 4; rd = int'(w[11:7]); rs1 = int'(w[19:15]); rs2 = int'(w[24:20]);
               if (f7 == 0) begin
                  legal = 1'b1; func = ALU_FN[f3];
               end else if (f7 == 32 && (f3 == 0 || f3 == 5)) begin
                  legal = 1'b1; func = (f3 == 0) ? 1 : 9;
               end
`endif
            end
            default: legal = 1'b0;
         endcase
      end
      if (!legal) return mk(0, 0, 0, 0, 0, 32'd0, pc, 1'b1);
      return mk(kind, func, rd, rs1, rs2, imm, pc, 1'b0);
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      int sel;
      w = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
         3:       w[6:0] = 7'h37;
         4:       w[6:0] = 7'h17;
         5, 6:    w[6:0] = 7'h33;
         7:       w[6:0] = w[6:0];
         default: w[6:0] = 7'h13;
      endcase
      if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20;
      return w;
   endfunction

   // Advance one clock and update the model from the handshake rules.
   task automatic tick();
      bit acc, deq;
      logic [86:0] rec;
      acc = in_valid && (exp_q.size() < DEPTH) && !flush;
      deq = (exp_q.size() != 0) && out_ready && !flush;
      rec = ref_decode(in_instr, in_pc);
      if (out_valid && out_ready && !flush) obs_pc.push_back(out_pc);
      @(posedge clk);
      if (flush) begin
         exp_q.delete();
      end else begin
         if (deq) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(rec);
      end
      last_acc = acc;
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({count, out_valid, obs_rec()} !== {CW'(0), 1'b0, 87'd0}) begin
         failures++;
         $display("FAIL reset_state got count=%0d valid=%0b rec=%h exp all zero", count, out_valid, obs_rec());
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
      end
      in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h50;
      tick();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({count, out_valid} !== {CW'(0), 1'b0}) begin
         failures++;
         $display("FAIL reset_midflight got count=%0d valid=%0b exp 0 0", count, out_valid);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_addi();
      out_ready = 1'b1;
      in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h100;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL addi_no_bypass got valid=%0b exp=0", out_valid);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if ({out_valid, count, obs_rec()} !== {1'b1, CW'(1), mk(1, 0, 1, 0, 0, 32'hFFFFFFFF, 32'h100, 1'b0)}) begin
         failures++;
         $display("FAIL addi_rec got valid=%0b count=%0d rec=%h exp=%h", out_valid, count, obs_rec(),
                  mk(1, 0, 1, 0, 0, 32'hFFFFFFFF, 32'h100, 1'b0));
      end
      tick();
      checks++;
      if ({out_valid, count} !== {1'b0, CW'(0)}) begin
         failures++;
         $display("FAIL addi_drain got valid=%0b count=%0d exp 0 0", out_valid, count);
      end
   endtask

   task automatic test_lui_srai();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h123452B7; in_pc = 32'h200;
      tick();
      in_instr = 32'h4041D113; in_pc = 32'h204;
      tick();
      in_valid = 1'b0;
      checks++;
      if (obs_rec() !== mk(2, 0, 5, 0, 0, 32'h12345000, 32'h200, 1'b0)) begin
         failures++;
         $display("FAIL lui_rec got=%h exp=%h", obs_rec(), mk(2, 0, 5, 0, 0, 32'h12345000, 32'h200, 1'b0));
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (obs_rec() !== mk(1, 9, 2, 3, 0, 32'd4, 32'h204, 1'b0)) begin
         failures++;
         $display("FAIL srai_rec got=%h exp=%h", obs_rec(), mk(1, 9, 2, 3, 0, 32'd4, 32'h204, 1'b0));
      end
      tick();
   endtask

   task automatic test_illegal();
      out_ready = 1'b1;
      in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 32'h400;
      tick();
      in_instr = 32'h02009093; in_pc = 32'h404;
      checks++;
      if (obs_rec() !== mk(0, 0, 0, 0, 0, 32'd0, 32'h400, 1'b1)) begin
         failures++;
         $display("FAIL illegal_zero got=%h exp=%h", obs_rec(), mk(0, 0, 0, 0, 0, 32'd0, 32'h400, 1'b1));
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (obs_rec() !== mk(0, 0, 0, 0, 0, 32'd0, 32'h404, 1'b1)) begin
         failures++;
         $display("FAIL illegal_slli got=%h exp=%h", obs_rec(), mk(0, 0, 0, 0, 0, 32'd0, 32'h404, 1'b1));
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] instrs [3];
      int idx;
      instrs = '{32'h00100093, 32'h00200113, 32'h00300193};
      idx = 0;
      obs_pc.delete();
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1; in_instr = instrs[idx]; in_pc = 32'h300 + 32'(4 * idx);
         tick();
         if (last_acc) idx++;
      end
      checks++;
      if ({count, in_ready, out_valid} !== {CW'(2), 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL full_state got count=%0d ready=%0b valid=%0b exp 2 0 1", count, in_ready, out_valid);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 10 && (idx < 3 || exp_q.size() != 0); c++) begin
         in_valid = (idx < 3);
         in_instr = instrs[(idx < 3) ? idx : 2];
         in_pc = 32'h300 + 32'(4 * idx);
         #1;
         checks++;
         if ({in_ready, obs_rec()} !== {exp_q.size() < DEPTH, exp_head()}) begin
            failures++;
            $display("FAIL drain_head got ready=%0b rec=%h exp ready=%0b rec=%h", in_ready, obs_rec(),
                     exp_q.size() < DEPTH, exp_head());
         end
         tick();
         if (last_acc) idx++;
      end
      in_valid = 1'b0;
      checks++;
      if (obs_pc.size() != 3 || obs_pc[0] !== 32'h300 || obs_pc[1] !== 32'h304 || obs_pc[2] !== 32'h308) begin
         failures++;
         $display("FAIL order got n=%0d first=%h exp 3 entries 300,304,308", obs_pc.size(),
                  (obs_pc.size() != 0) ? obs_pc[0] : 32'd0);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00500293; in_pc = 32'h500;
      tick();
      in_pc = 32'h504;
      tick();
      checks++;
      if (count !== CW'(2)) begin
         failures++;
         $display("FAIL flush_prefill got count=%0d exp=2", count);
      end
      in_pc = 32'h508; flush = 1'b1; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL flush_in_ready got=%0b exp=0", in_ready);
      end
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++;
      if ({count, out_valid, obs_rec()} !== {CW'(0), 1'b0, 87'd0}) begin
         failures++;
         $display("FAIL flush_empty got count=%0d valid=%0b rec=%h exp empty", count, out_valid, obs_rec());
      end
      tick();
      checks++;
      if (count !== CW'(0)) begin
         failures++;
         $display("FAIL flush_no_enqueue got count=%0d exp=0", count);
      end
   endtask

   task automatic test_op_reg();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h402081B3; in_pc = 32'h600;
      tick();
      in_valid = 1'b0;
      checks++;
`ifdef DECODER_OP_REG_EN
      if (obs_rec() !== mk(4, 1, 3, 1, 2, 32'd0, 32'h600, 1'b0)) begin
         failures++;
         $display("FAIL sub_rec got=%h exp=%h", obs_rec(), mk(4, 1, 3, 1, 2, 32'd0, 32'h600, 1'b0));
      end
`else
      if (obs_rec() !== mk(0, 0, 0, 0, 0, 32'd0, 32'h600, 1'b1)) begin
         failures++;
         $display("FAIL sub_rec got=%h exp=%h", obs_rec(), mk(0, 0, 0, 0, 0, 32'd0, 32'h600, 1'b1));
      end
`endif
      out_ready = 1'b1;
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         if (!in_valid || last_acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = rand_instr();
            in_pc = $urandom & 32'hFFFFFFFC;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 19) == 0);
         #1;
         checks++;
         if ({count, out_valid, in_ready, obs_rec()} !==
             {CW'(exp_q.size()), exp_q.size() != 0, (exp_q.size() < DEPTH) && !flush, exp_head()}) begin
            failures++;
            $display("FAIL random_cycle%0d got count=%0d valid=%0b ready=%0b rec=%h exp count=%0d rec=%h",
                     c, count, out_valid, in_ready, obs_rec(), exp_q.size(), exp_head());
         end
         tick();
      end
      flush = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_addi();
      test_lui_srai();
      test_illegal();
      test_back_to_back();
      test_flush();
      test_op_reg();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
